// File: rtl/spi_xfer_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_xfer_arbiter_if : requester + SPI-master signal bundle             |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface spi_xfer_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic               spi_start;
  logic [DW-1:0]      spi_din;
  logic [DW-1:0]      spi_dout;
  logic               spi_cs;

  // master is the arbiter; slave is everything around it (requesters, SPI master)
  modport master (
    input  req, req_data, spi_dout, spi_cs,
    output gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_err, spi_start, spi_din
  );

  modport slave (
    output req, req_data, spi_dout, spi_cs,
    input  gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_err, spi_start, spi_din
  );
endinterface
`default_nettype wire

// File: rtl/spi_xfer_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_xfer_arbiter : round-robin sharing of one SPI master, with CS watchdog |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module spi_xfer_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  spi_xfer_arbiter_if.master bus
);
  localparam int             IDW       = $clog2(NREQ);
  localparam logic [7:0]     C_TIMEOUT = 8'(TIMEOUT);
  localparam logic [IDW-1:0] C_LAST    = IDW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            cs_q, cs_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   din_q, din_d;
  logic [DW-1:0]   data_q, data_d;
  logic            err_q, err_d;

  logic            sel_found;
  logic [IDW-1:0]  sel_idx;
  logic [IDW-1:0]  cand;

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cs_d    = bus.spi_cs;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    din_d   = din_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d        = S_LAUNCH;
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          id_d           = sel_idx;
          din_d          = bus.req_data[sel_idx*DW +: DW];
          data_d         = '0;
          err_d          = 1'b0;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!bus.spi_cs) begin
          cnt_d   = '0;
          state_d = S_WAIT_HI;
        end else if (cnt_q == C_TIMEOUT) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_HI: begin
        // A completed CS rise wins over a coincident watchdog expiry.
        if (bus.spi_cs && !cs_q) begin
          data_d  = bus.spi_dout;
          state_d = S_DONE;
        end else if (cnt_q == C_TIMEOUT) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = (id_q == C_LAST) ? '0 : id_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cs_q    <= 1'b1;
      cnt_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      din_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      din_q   <= din_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign bus.spi_start = (state_q == S_LAUNCH);
  assign bus.spi_din   = din_q;

endmodule
`default_nettype wire

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Round-robin arbiter and transfer sequencer that shares one SPI master (the `spi_top` master side) between `NREQ` on-chip requesters. It grants one requester at a time and drives the master's start/data inputs. It tracks chip-select to detect the end of the transfer, then returns the received byte to the granted requester, tagged with its ID. A watchdog aborts transfers whose chip-select never completes.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DW`, 8: SPI word width.
- `TIMEOUT`, 255: maximum cycles spent waiting in each CS phase before abort (8-bit counter, 1..255).
- `clk`  in  1  single system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request level; held until that requester sees `rsp_valid` with its ID.
- `req_data`  in  NREQ*DW  byte to transmit; requester i occupies bits [i*DW +: DW]; held with `req`.
- `gnt`  out  NREQ  one-hot grant; asserted from grant cycle through the DONE cycle.
- `busy`  out  1  high whenever state is not IDLE.
- `rsp_valid`  out  1  one-cycle pulse: transfer finished.
- `rsp_id`  out  clog2(NREQ)  index of the requester the response belongs to.
- `rsp_data`  out  DW  byte received from the slave (master's `dout`), valid with `rsp_valid`.
- `rsp_err`  out  1  with `rsp_valid`: 1 = timeout abort, `rsp_data` = 0.
- `spi_start`  out  1  one-cycle start pulse to the SPI master.
- `spi_din`  out  DW  transmit byte to the SPI master, held from LAUNCH through DONE.
- `spi_dout`  in  DW  received byte from the SPI master.
- `spi_cs`  in  1  master chip-select, active-low (high = idle); same clock domain.

## Operation
- States: IDLE, LAUNCH, WAIT_LO, WAIT_HI, DONE.
- IDLE: if any `req` is high, select the first requester at or after `ptr` (wrapping modulo NREQ). Register `gnt`, `rsp_id`, and `spi_din` from that requester's `req_data`. Go to LAUNCH.
- LAUNCH: `spi_start`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_LO.
- WAIT_LO: wait for `spi_cs`=0 (transfer begun) and go to WAIT_HI. Counter increments each cycle; reaching `TIMEOUT` sets the error flag and goes to DONE.
- WAIT_HI: wait for a rising edge of `spi_cs`, detected with a registered `cs_q`: `spi_cs`=1 and `cs_q`=0. On the edge, capture `spi_dout` into `rsp_data` and go to DONE. Counter restarts at 0 on entry; reaching `TIMEOUT` sets the error flag and goes to DONE.
- DONE: `rsp_valid`=1 with `rsp_data`, `rsp_id` and `rsp_err`. Set `ptr` = granted index + 1 (mod NREQ). Clear `gnt` and go to IDLE.
- Fairness: a continuously requesting client waits at most NREQ-1 transfers.
- `req` dropping mid-transfer is ignored: the transfer completes and the response is still issued.
- Changes to `req_data` after the grant cycle have no effect.
- Reset (any state, asynchronous): state=IDLE, `ptr`=0, `cs_q`=1, counter=0.
- Reset values of all outputs: `gnt`, `busy`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `spi_start` and `spi_din` are all 0.
- Reset mid-transfer drops the in-flight response; the SPI master is reset by the same net.

## Timing
- Grant latency: `req` high in IDLE at cycle N gives `gnt` and `busy` at N+1 (LAUNCH) and `spi_start` at N+1.
- Response latency: CS rising edge seen at cycle M gives `rsp_valid` at M+1. `gnt` falls at M+2, and IDLE can re-grant at M+2.
- Minimum gap between back-to-back `spi_start` pulses: transfer length + 4 cycles.
- Timeout from LAUNCH to `rsp_valid` with no CS activity: TIMEOUT+2 cycles.
- `rsp_valid` is never high for two consecutive cycles; `spi_start` is never high outside LAUNCH.

## Test plan
- Single request: after reset, `req`=0001, `req_data[7:0]`=8'hAA, slave byte 8'hCC -> one `spi_start` pulse and `gnt`=0001. `rsp_valid` comes one cycle after the CS rise with `rsp_id`=0, `rsp_data`=8'hCC, `rsp_err`=0. The slave receives 8'hAA.
- Round-robin: `req`=1111 held for eight transfers, requester i sending 8'h10+i -> grant order 0,1,2,3,0,1,2,3. `rsp_id` matches each grant, and each `rsp_data` equals the slave byte for that transfer.
- Pointer wrap: grant requester 3 alone, then `req`=1001 -> next grant is requester 0, then requester 3.
- Timeout: `spi_cs` forced high, `req`=0100, `TIMEOUT`=16 -> `rsp_valid` 18 cycles after `spi_start` with `rsp_err`=1, `rsp_data`=0, `rsp_id`=2. Returns to IDLE.
- Requester drop: requester 1 deasserts `req` while in WAIT_HI -> the transfer completes and `rsp_valid` is issued with `rsp_id`=1.
- Async reset mid-transfer: `reset_n` pulsed low while in WAIT_HI -> all outputs are 0 immediately, no `rsp_valid` follows, and the next request is granted starting from `ptr`=0.
